lsb_queue: RTL and testbench
============================

# lsb_queue

Parametrised in-order load/store buffer between the dispatch/ROB stage and the memory controller. It holds up to DEPTH memory ops and captures missing operands from CDB_N result buses. It issues one memory transaction at a time from the head: loads as soon as their operands are ready, stores only after the ROB commits them. Load results are broadcast on its own result port, and a flush discards all speculative entries while committed stores keep draining.

## Interface
Parameters:
- DEPTH, 16, entry count; power of two, ≥2
- TAG_W, 4, ROB tag width
- CDB_N, 2, number of snooped result buses

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; low freezes all state and outputs
- enq_valid  in  1  enqueue request
- enq_ready  out  1  high when not full; enqueue occurs on enq_valid & enq_ready
- enq_store  in  1  1 = store, 0 = load
- enq_size  in  2  0 = byte, 1 = half, 2 = word
- enq_unsigned  in  1  load zero-extends when set
- enq_tag  in  TAG_W  ROB tag of the op
- enq_imm  in  32  address offset
- enq_rs1_val / enq_rs2_val  in  32  operand value if ready, otherwise low TAG_W bits are the producer tag
- enq_rs1_rdy / enq_rs2_rdy  in  1  operand ready
- cdb_valid  in  CDB_N  bus valid
- cdb_tag  in  CDB_N*TAG_W  packed tags, channel 0 in LSBs
- cdb_data  in  CDB_N*32  packed values
- commit_valid  in  1  ROB commits a store this cycle
- commit_tag  in  TAG_W  tag of the committed store
- flush  in  1  mispredict flush
- mem_req  out  1  transaction request, held until ack
- mem_we  out  1  store
- mem_size  out  2  as enq_size
- mem_addr  out  32  rs1 + imm
- mem_wdata  out  32  store data
- mem_ack  in  1  one-cycle completion pulse
- mem_rdata  in  32  load data, valid with mem_ack
- out_valid  out  1  load result pulse
- out_tag  out  TAG_W  ROB tag
- out_data  out  32  extended load data
- count  out  log2(DEPTH)+1  occupancy

## Operation
- Circular queue with head/tail pointers of log2(DEPTH) bits plus a wrap bit. full = count==DEPTH; empty = count==0. Pointers wrap modulo DEPTH.
- Entry fields: op, size, unsigned flag, tag, imm, rs1/rs2 value and ready bit, committed bit.
- Operand capture: every cycle, each valid entry's not-ready operand whose tag equals any valid cdb_tag takes that channel's data. On multiple matches, the lowest channel wins. An enqueuing operand is also compared against the same-cycle CDB buses and is captured ready.
- Commit: on commit_valid, the valid store whose tag equals commit_tag sets its committed bit. This includes a store enqueued in the same cycle.
- FSM IDLE → WAIT → DONE → IDLE.
  - IDLE: the head is valid, both operands are ready, and it is either a load or a committed store → register mem_* and go to WAIT.
  - WAIT: hold mem_* stable until mem_ack. On mem_ack, latch rdata and go to DONE.
  - DONE: pop the head. For a load that has not been discarded, pulse out_valid. Return to IDLE.
- Load data: byte = rdata[7:0], half = rdata[15:0], each sign- or zero-extended per the unsigned flag; word = rdata as-is.
- Store data: mem_wdata = rs2 with bits above the size zeroed.
- Addresses are 32-bit with wrap-around and no alignment check.
- Flush:
  - All uncommitted entries are invalidated.
  - Tail is set to head plus the number of committed stores. Committed stores always form a contiguous prefix from head.
  - If a load is in WAIT, the transaction completes, but its result is dropped (discard flag) and its entry is popped.
  - A flush takes priority over a same-cycle enqueue, which is dropped.
- Same-cycle enqueue and pop are allowed at full; enq_ready still reflects the registered full, so no enqueue is accepted while full.

## Timing
- Reset values:
  - mem_req, mem_we, out_valid = 0
  - mem_addr, mem_wdata, out_data, out_tag, mem_size = 0
  - count = 0, enq_ready = 1, FSM in IDLE, all entries invalid
- A head that becomes eligible in cycle N raises mem_req in N+1.
- mem_ack in cycle M produces out_valid in M+1, with count decremented in M+1.
- The next head's mem_req rises no earlier than M+2.
- The throughput floor is one op per 3 cycles with zero-wait memory.
- A CDB value captured in cycle N makes the operand eligible in N+1.
- rst is honoured regardless of rdy. rst in WAIT abandons the transaction, and the memory controller is reset together with this block.

## Configuration
- LSB_PERF_EN defined: adds three 32-bit saturating output counters, reset to 0.
  - perf_loads: completed loads
  - perf_stores: completed stores
  - perf_stall: cycles with a valid head in IDLE that is not eligible
- LSB_PERF_EN undefined: the ports and logic are absent, and all other behaviour is identical.

## Test plan
- Ready LW, imm=4, rs1=0x100; ack returns 0xDEADBEEF → mem_addr=0x104 and mem_size=2; one cycle after ack, out_valid=1, out_data=0xDEADBEEF, out_tag=enq_tag.
- LB from 0x200 with rdata=0x00000080, signed then unsigned → out_data=0xFFFFFF80 then 0x00000080.
- SB with rs2 not ready (tag 3); cdb channel 1 drives tag 3, data 0x1234ABCD; commit tag 5 → mem_req only after commit, mem_we=1, mem_wdata=0x000000CD.
- Enqueue DEPTH loads with rs1 pending → enq_ready=0 and count=DEPTH; the first completion restores enq_ready in the same cycle that count drops.
- One committed SW followed by 3 pending loads; flush asserted while the SW is in WAIT → count=1 after flush, the SW completes, no out_valid, queue empty.
- Load in WAIT when flush fires → the ack is consumed, no out_valid, count=0, next enqueue accepted normally.

Source files
------------

// File: rtl/lsb_queue.sv
// lsb_queue: in-order load/store buffer with CDB operand capture and head-only memory issue.
// Define LSB_PERF_EN to add the perf_loads/perf_stores/perf_stall counters.
module lsb_queue #(
   parameter int DEPTH = 16,
   parameter int TAG_W = 4,
   parameter int CDB_N = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    rdy,
   input  logic                    enq_valid,
   output logic                    enq_ready,
   input  logic                    enq_store,
   input  logic [1:0]              enq_size,
   input  logic                    enq_unsigned,
   input  logic [TAG_W-1:0]        enq_tag,
   input  logic [31:0]             enq_imm,
   input  logic [31:0]             enq_rs1_val,
   input  logic [31:0]             enq_rs2_val,
   input  logic                    enq_rs1_rdy,
   input  logic                    enq_rs2_rdy,
   input  logic [CDB_N-1:0]        cdb_valid,
   input  logic [CDB_N*TAG_W-1:0]  cdb_tag,
   input  logic [CDB_N*32-1:0]     cdb_data,
   input  logic                    commit_valid,
   input  logic [TAG_W-1:0]        commit_tag,
   input  logic                    flush,
   output logic                    mem_req,
   output logic                    mem_we,
   output logic [1:0]              mem_size,
   output logic [31:0]             mem_addr,
   output logic [31:0]             mem_wdata,
   input  logic                    mem_ack,
   input  logic [31:0]             mem_rdata,
   output logic                    out_valid,
   output logic [TAG_W-1:0]        out_tag,
   output logic [31:0]             out_data,
`ifdef LSB_PERF_EN
   output logic [31:0]             perf_loads,
   output logic [31:0]             perf_stores,
   output logic [31:0]             perf_stall,
`endif
   output logic [$clog2(DEPTH):0]  count
);
   localparam int PW = $clog2(DEPTH);
   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;
   state_e state_q, state_d;
   logic [PW:0] head_q, head_d, tail_q, tail_d;
   logic [DEPTH-1:0] v_q, v_d, st_q, st_d, un_q, un_d, r1r_q, r1r_d, r2r_q, r2r_d, cm_q, cm_d;
   logic [1:0] sz_q [DEPTH], sz_d [DEPTH];
   logic [TAG_W-1:0] tag_q [DEPTH], tag_d [DEPTH];
   logic [31:0] imm_q [DEPTH], imm_d [DEPTH], r1_q [DEPTH], r1_d [DEPTH], r2_q [DEPTH], r2_d [DEPTH];
   logic mem_req_q, mem_req_d, mem_we_q, mem_we_d, disc_q, disc_d, out_valid_q, out_valid_d;
   logic [1:0] mem_size_q, mem_size_d;
   logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d, out_data_q, out_data_d;
   logic [TAG_W-1:0] out_tag_q, out_tag_d;
   logic [PW-1:0] h, t;
   logic full, elig, launch, ack, enq;
   logic [31:0] ld, wd;

   function automatic logic [32:0] snoop(input logic r, input logic [31:0] x);
      logic [32:0] s;
      s = {r, x};
      for (int c = CDB_N - 1; c >= 0; c--)
         if (!r && cdb_valid[c] && cdb_tag[c*TAG_W +: TAG_W] == x[TAG_W-1:0]) s = {1'b1, cdb_data[c*32 +: 32]};
      return s;
   endfunction

   assign h = head_q[PW-1:0];
   assign t = tail_q[PW-1:0];
   assign count = tail_q - head_q;
   assign full = count[PW];
   assign enq_ready = ~full;
   assign elig = v_q[h] & r1r_q[h] & r2r_q[h] & (~st_q[h] | cm_q[h]);
   // A flush holds off a new issue for one cycle so nothing speculative leaves the block.
   assign launch = state_q == IDLE && elig && !flush;
   assign ack = state_q == WAIT && mem_ack;
   assign enq = enq_valid & ~full & ~flush;
   assign ld = sz_q[h] == 2'd0 ? {{24{~un_q[h] & mem_rdata[7]}}, mem_rdata[7:0]} :
               sz_q[h] == 2'd1 ? {{16{~un_q[h] & mem_rdata[15]}}, mem_rdata[15:0]} : mem_rdata;
   assign wd = sz_q[h] == 2'd0 ? {24'd0, r2_q[h][7:0]} : sz_q[h] == 2'd1 ? {16'd0, r2_q[h][15:0]} : r2_q[h];

   always_ff @(posedge clk)
      if (rst) state_q <= IDLE;
      else if (rdy) state_q <= state_d;

   always_comb state_d = launch ? WAIT : ack ? DONE : state_q == DONE ? IDLE : state_q;

   always_comb begin
      mem_req_d = launch | (mem_req_q & ~ack);
      mem_we_d = launch ? st_q[h] : mem_we_q;
      mem_size_d = launch ? sz_q[h] : mem_size_q;
      mem_addr_d = launch ? r1_q[h] + imm_q[h] : mem_addr_q;
      mem_wdata_d = launch ? wd : mem_wdata_q;
      out_valid_d = ack & ~mem_we_q & ~disc_q & ~flush;
      out_tag_d = ack && !mem_we_q ? tag_q[h] : out_tag_q;
      out_data_d = ack && !mem_we_q ? ld : out_data_q;
      disc_d = ~ack & (disc_q | (flush & state_q == WAIT & ~mem_we_q));
   end

   always_comb begin
      logic [PW:0] ncm;
      v_d = v_q;
      st_d = st_q;
      un_d = un_q;
      cm_d = cm_q;
      r1r_d = r1r_q;
      r2r_d = r2r_q;
      sz_d = sz_q;
      tag_d = tag_q;
      imm_d = imm_q;
      r1_d = r1_q;
      r2_d = r2_q;
      head_d = head_q;
      tail_d = tail_q;
      ncm = '0;
      for (int i = 0; i < DEPTH; i++)
         if (v_q[i]) begin
            {r1r_d[i], r1_d[i]} = snoop(r1r_q[i], r1_q[i]);
            {r2r_d[i], r2_d[i]} = snoop(r2r_q[i], r2_q[i]);
            cm_d[i] = cm_q[i] | (st_q[i] & commit_valid & (tag_q[i] == commit_tag));
         end
      if (enq) begin
         v_d[t] = 1'b1;
         st_d[t] = enq_store;
         un_d[t] = enq_unsigned;
         sz_d[t] = enq_size;
         tag_d[t] = enq_tag;
         imm_d[t] = enq_imm;
         {r1r_d[t], r1_d[t]} = snoop(enq_rs1_rdy, enq_rs1_val);
         {r2r_d[t], r2_d[t]} = snoop(enq_rs2_rdy, enq_rs2_val);
         cm_d[t] = enq_store & commit_valid & (enq_tag == commit_tag);
         tail_d = tail_q + (PW+1)'(1);
      end
      // The in-flight head stays allocated until its ack pops it, even when it is a discarded load.
      if (flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            ncm = ncm + (PW+1)'(v_q[i] & cm_d[i]);
            if (!cm_d[i] && !(state_q == WAIT && PW'(i) == h)) v_d[i] = 1'b0;
         end
         tail_d = head_q + ncm + (PW+1)'(state_q == WAIT && !mem_we_q);
      end
      if (ack) begin
         v_d[h] = 1'b0;
         head_d = head_q + (PW+1)'(1);
      end
   end

   always_ff @(posedge clk)
      if (rst) begin
         head_q <= '0;
         tail_q <= '0;
         v_q <= '0;
         cm_q <= '0;
         mem_req_q <= 1'b0;
         mem_we_q <= 1'b0;
         mem_size_q <= '0;
         mem_addr_q <= '0;
         mem_wdata_q <= '0;
         out_valid_q <= 1'b0;
         out_tag_q <= '0;
         out_data_q <= '0;
         disc_q <= 1'b0;
      end else if (rdy) begin
         head_q <= head_d;
         tail_q <= tail_d;
         v_q <= v_d;
         st_q <= st_d;
         un_q <= un_d;
         cm_q <= cm_d;
         r1r_q <= r1r_d;
         r2r_q <= r2r_d;
         sz_q <= sz_d;
         tag_q <= tag_d;
         imm_q <= imm_d;
         r1_q <= r1_d;
         r2_q <= r2_d;
         mem_req_q <= mem_req_d;
         mem_we_q <= mem_we_d;
         mem_size_q <= mem_size_d;
         mem_addr_q <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         out_valid_q <= out_valid_d;
         out_tag_q <= out_tag_d;
         out_data_q <= out_data_d;
         disc_q <= disc_d;
      end

   assign mem_req = mem_req_q;
   assign mem_we = mem_we_q;
   assign mem_size = mem_size_q;
   assign mem_addr = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign out_valid = out_valid_q;
   assign out_tag = out_tag_q;
   assign out_data = out_data_q;

`ifdef LSB_PERF_EN
   always_ff @(posedge clk)
      if (rst) begin
         perf_loads <= '0;
         perf_stores <= '0;
         perf_stall <= '0;
      end else if (rdy) begin
         if (ack && !mem_we_q && !(&perf_loads)) perf_loads <= perf_loads + 32'd1;
         if (ack && mem_we_q && !(&perf_stores)) perf_stores <= perf_stores + 32'd1;
         if (state_q == IDLE && v_q[h] && !elig && !(&perf_stall)) perf_stall <= perf_stall + 32'd1;
      end
`endif
endmodule

// File: tb/tb_lsb_queue.sv
// tb_lsb_queue: directed stimulus with a request/result scoreboard and a small memory responder.
module tb_lsb_queue;
   localparam int DEPTH = 16;
   localparam int TAG_W = 4;
   localparam int CDB_N = 2;
   typedef struct packed {logic we; logic [1:0] sz; logic [31:0] addr; logic [31:0] wd;} mreq_t;
   typedef struct packed {logic [TAG_W-1:0] tag; logic [31:0] data;} ores_t;
   logic clk = 1'b0, rst, rdy, enq_valid, enq_ready, enq_store, enq_unsigned, enq_rs1_rdy, enq_rs2_rdy;
   logic commit_valid, flush, mem_req, mem_we, mem_ack, out_valid;
   logic [1:0] enq_size, mem_size;
   logic [TAG_W-1:0] enq_tag, commit_tag, out_tag;
   logic [31:0] enq_imm, enq_rs1_val, enq_rs2_val, mem_addr, mem_wdata, mem_rdata, out_data;
   logic [CDB_N-1:0] cdb_valid;
   logic [CDB_N*TAG_W-1:0] cdb_tag;
   logic [CDB_N*32-1:0] cdb_data;
   logic [$clog2(DEPTH):0] count;
`ifdef LSB_PERF_EN
   logic [31:0] perf_loads, perf_stores, perf_stall;
`endif
   mreq_t exp_mem[$];
   ores_t exp_out[$];
   logic [31:0] rd_q[$];
   mreq_t mon_m;
   ores_t mon_o;
   logic req_prev = 1'b0;
   int checks = 0, errors = 0, lat = 0, n;

   lsb_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .CDB_N(CDB_N)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .enq_valid(enq_valid), .enq_ready(enq_ready),
      .enq_store(enq_store), .enq_size(enq_size), .enq_unsigned(enq_unsigned), .enq_tag(enq_tag),
      .enq_imm(enq_imm), .enq_rs1_val(enq_rs1_val), .enq_rs2_val(enq_rs2_val),
      .enq_rs1_rdy(enq_rs1_rdy), .enq_rs2_rdy(enq_rs2_rdy), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
      .cdb_data(cdb_data), .commit_valid(commit_valid), .commit_tag(commit_tag), .flush(flush),
      .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .out_valid(out_valid),
      .out_tag(out_tag), .out_data(out_data),
`ifdef LSB_PERF_EN
      .perf_loads(perf_loads), .perf_stores(perf_stores), .perf_stall(perf_stall),
`endif
      .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic enq(input logic st, input logic [1:0] sz, input logic un, input logic [TAG_W-1:0] tg,
                      input logic [31:0] imm, input logic [31:0] r1, input logic r1r,
                      input logic [31:0] r2, input logic r2r);
      enq_valid = 1'b1;
      enq_store = st;
      enq_size = sz;
      enq_unsigned = un;
      enq_tag = tg;
      enq_imm = imm;
      enq_rs1_val = r1;
      enq_rs1_rdy = r1r;
      enq_rs2_val = r2;
      enq_rs2_rdy = r2r;
      step();
      enq_valid = 1'b0;
   endtask

   task automatic cdb(input logic [CDB_N-1:0] v, input logic [CDB_N*TAG_W-1:0] tg, input logic [CDB_N*32-1:0] d);
      cdb_valid = v;
      cdb_tag = tg;
      cdb_data = d;
      step();
      cdb_valid = '0;
   endtask

   task automatic exp_req(input logic we, input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] wd);
      exp_mem.push_back(mreq_t'{we, sz, addr, wd});
   endtask

   task automatic exp_ld(input logic [TAG_W-1:0] tg, input logic [31:0] data, input logic [31:0] rd);
      exp_out.push_back(ores_t'{tg, data});
      rd_q.push_back(rd);
   endtask

   task automatic drain(input string name);
      int k;
      k = 0;
      while ((exp_mem.size() != 0 || exp_out.size() != 0 || count != 0 || mem_req) && k < 300) begin
         @(negedge clk);
         k++;
      end
      repeat (5) @(negedge clk);
      chk({name, " drained"}, 32'(k < 300), 32'd1);
      chk({name, " count"}, 32'(count), 32'd0);
   endtask

   initial begin
      mem_ack = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (mem_req && !mem_ack) begin
            repeat (lat) @(negedge clk);
            mem_ack = 1'b1;
            mem_rdata = rd_q.size() != 0 ? rd_q.pop_front() : 32'd0;
            @(negedge clk);
            mem_ack = 1'b0;
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (mem_req && !req_prev) begin
         if (exp_mem.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mem_req unexpected: addr %h we %b", mem_addr, mem_we);
         end else begin
            mon_m = exp_mem.pop_front();
            chk("mem_we", 32'(mem_we), 32'(mon_m.we));
            chk("mem_size", 32'(mem_size), 32'(mon_m.sz));
            chk("mem_addr", mem_addr, mon_m.addr);
            if (mon_m.we) chk("mem_wdata", mem_wdata, mon_m.wd);
         end
      end
      req_prev = mem_req;
      if (out_valid) begin
         if (exp_out.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL out_valid unexpected: tag %h data %h", out_tag, out_data);
         end else begin
            mon_o = exp_out.pop_front();
            chk("out_tag", 32'(out_tag), 32'(mon_o.tag));
            chk("out_data", out_data, mon_o.data);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      rdy = 1'b1;
      enq_valid = 1'b0;
      enq_store = 1'b0;
      enq_size = '0;
      enq_unsigned = 1'b0;
      enq_tag = '0;
      enq_imm = '0;
      enq_rs1_val = '0;
      enq_rs2_val = '0;
      enq_rs1_rdy = 1'b0;
      enq_rs2_rdy = 1'b0;
      cdb_valid = '0;
      cdb_tag = '0;
      cdb_data = '0;
      commit_valid = 1'b0;
      commit_tag = '0;
      flush = 1'b0;
      repeat (3) step();
      rst = 1'b0;
      @(negedge clk);
      chk("reset count", 32'(count), 32'd0);
      chk("reset enq_ready", 32'(enq_ready), 32'd1);
      chk("reset mem_req", 32'(mem_req), 32'd0);
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset mem_addr", mem_addr, 32'd0);
      chk("reset out_data", out_data, 32'd0);
      step();
      // ready LW: request one cycle after the entry lands, result one cycle after ack
      exp_req(1'b0, 2'd2, 32'h104, 32'd0);
      exp_ld(4'd1, 32'hDEADBEEF, 32'hDEADBEEF);
      enq(1'b0, 2'd2, 1'b0, 4'd1, 32'd4, 32'h100, 1'b1, 32'd0, 1'b1);
      @(negedge clk);
      chk("lw req before eligible", 32'(mem_req), 32'd0);
      @(negedge clk);
      chk("lw req", 32'(mem_req), 32'd1);
      chk("lw count in flight", 32'(count), 32'd1);
      @(negedge clk);
      chk("lw out_valid after ack", 32'(out_valid), 32'd1);
      chk("lw count after ack", 32'(count), 32'd0);
      drain("lw");
      step();
      // LB signed then unsigned
      exp_req(1'b0, 2'd0, 32'h200, 32'd0);
      exp_ld(4'd2, 32'hFFFFFF80, 32'h00000080);
      exp_req(1'b0, 2'd0, 32'h200, 32'd0);
      exp_ld(4'd3, 32'h00000080, 32'h00000080);
      enq(1'b0, 2'd0, 1'b0, 4'd2, 32'd0, 32'h200, 1'b1, 32'd0, 1'b1);
      enq(1'b0, 2'd0, 1'b1, 4'd3, 32'd0, 32'h200, 1'b1, 32'd0, 1'b1);
      drain("lb");
      step();
      // SB waits on CDB channel 1 and then on commit
      exp_req(1'b1, 2'd0, 32'h300, 32'h000000CD);
      enq(1'b1, 2'd0, 1'b0, 4'd5, 32'd0, 32'h300, 1'b1, 32'd3, 1'b0);
      repeat (4) @(negedge clk);
      chk("sb req while rs2 pending", 32'(mem_req), 32'd0);
      step();
      cdb(2'b10, 8'h30, {32'h1234ABCD, 32'h0});
      repeat (3) @(negedge clk);
      chk("sb req before commit", 32'(mem_req), 32'd0);
      step();
      commit_valid = 1'b1;
      commit_tag = 4'd5;
      step();
      commit_valid = 1'b0;
      drain("sb");
      step();
      // SH: both channels match, channel 0 wins; address wraps past 2^32
      exp_req(1'b1, 2'd1, 32'h00000010, 32'h00005555);
      enq(1'b1, 2'd1, 1'b0, 4'd6, 32'h20, 32'hFFFFFFF0, 1'b1, 32'd2, 1'b0);
      cdb(2'b11, 8'h22, {32'h11112222, 32'hAAAA5555});
      commit_valid = 1'b1;
      commit_tag = 4'd6;
      step();
      commit_valid = 1'b0;
      drain("sh");
      step();
      // fill with pending loads, then release them all from one CDB broadcast
      for (int i = 0; i < DEPTH; i++) begin
         exp_req(1'b0, 2'd2, 32'h1000 + i * 4, 32'd0);
         exp_ld(TAG_W'(i), 32'h100 + i, 32'h100 + i);
         enq(1'b0, 2'd2, 1'b0, TAG_W'(i), i * 4, 32'd7, 1'b0, 32'd0, 1'b1);
      end
      @(negedge clk);
      chk("full count", 32'(count), 32'(DEPTH));
      chk("full enq_ready", 32'(enq_ready), 32'd0);
      step();
      enq(1'b0, 2'd2, 1'b0, 4'hF, 32'd0, 32'h999, 1'b1, 32'd0, 1'b1);
      @(negedge clk);
      chk("full enqueue refused", 32'(count), 32'(DEPTH));
      step();
      cdb(2'b01, 8'h07, {32'h0, 32'h1000});
      n = 0;
      while (count == DEPTH && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("first pop count", 32'(count), 32'(DEPTH - 1));
      chk("first pop enq_ready", 32'(enq_ready), 32'd1);
      chk("first pop out_valid", 32'(out_valid), 32'd1);
      drain("full");
      step();
      // committed SW in WAIT, three pending loads behind it, flush
      lat = 6;
      exp_req(1'b1, 2'd2, 32'h408, 32'h55667788);
      commit_valid = 1'b1;
      commit_tag = 4'd9;
      enq(1'b1, 2'd2, 1'b0, 4'd9, 32'd8, 32'h400, 1'b1, 32'h55667788, 1'b1);
      commit_valid = 1'b0;
      for (int i = 0; i < 3; i++) enq(1'b0, 2'd2, 1'b0, TAG_W'(10 + i), 32'd0, 32'd14, 1'b0, 32'd0, 1'b1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      @(negedge clk);
      chk("flush keeps committed store", 32'(count), 32'd1);
      chk("store still in flight", 32'(mem_req), 32'd1);
      step();
      cdb(2'b01, 8'h0E, {32'h0, 32'h2000});
      drain("flush sw");
      lat = 4;
      step();
      // load in WAIT when flush fires: ack consumed, result dropped
      exp_req(1'b0, 2'd2, 32'h500, 32'd0);
      rd_q.push_back(32'h11111111);
      enq(1'b0, 2'd2, 1'b0, 4'd4, 32'd0, 32'h500, 1'b1, 32'd0, 1'b1);
      n = 0;
      while (!mem_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("flushed load issued", 32'(mem_req), 32'd1);
      step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      drain("flush ld");
      lat = 0;
      step();
      exp_req(1'b0, 2'd1, 32'h610, 32'd0);
      exp_ld(4'd6, 32'hFFFF8001, 32'h00008001);
      enq(1'b0, 2'd1, 1'b0, 4'd6, 32'h10, 32'h600, 1'b1, 32'd0, 1'b1);
      drain("post flush lh");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
